// File: rtl/pnr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pnr_pkg
// Description : Shared constants and state encoding for the photon-number-
//               resolving acquisition sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pnr_pkg;

  localparam int ADC_W   = 14;  // ADC sample / threshold width
  localparam int NUM_W   = 3;   // photon-number width (0..7)
  localparam int NUM_THR = 7;   // number of photon thresholds

  // Sequencer states; the numeric encoding is visible to debug tooling.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DELAY    = 3'd1,
    ST_WINDOW   = 3'd2,
    ST_CLASSIFY = 3'd3,
    ST_HOLDOFF  = 3'd4
  } pnr_state_t;

endpackage
`default_nettype wire

// File: rtl/pnr_classifier.sv
`default_nettype none
// ============================================================================
// Module      : pnr_classifier
// Description : Combinational photon-number classifier. Counts how many of
//               the thresholds the window peak reaches (signed, peak >= thr).
//               Thresholds need not be ordered; each one is tested on its own.
// Ports       : i_peak  - signed window peak
//               i_thr   - thresholds packed as {thr_7, ..., thr_1}
//               o_num   - number of thresholds reached (0..NUM_THR)
// Revision    : 1.0 - initial release
// ============================================================================
module pnr_classifier #(
  parameter int ADC_W   = pnr_pkg::ADC_W,
  parameter int NUM_W   = pnr_pkg::NUM_W,
  parameter int NUM_THR = pnr_pkg::NUM_THR
) (
  input  logic [ADC_W-1:0]         i_peak,
  input  logic [NUM_THR*ADC_W-1:0] i_thr,
  output logic [NUM_W-1:0]         o_num
);

  logic [NUM_THR-1:0] w_hit;

  for (genvar k = 0; k < NUM_THR; k++) begin : g_cmp
    assign w_hit[k] = $signed(i_peak) >= $signed(i_thr[k*ADC_W +: ADC_W]);
  end

  always_comb begin
    o_num = '0;
    for (int k = 0; k < NUM_THR; k++) begin
      o_num = o_num + NUM_W'(w_hit[k]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pnr_acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pnr_acq_sequencer
// Description : Runs one photon-number-resolving measurement per armed
//               trigger rising edge: delay -> peak search over an ADC window
//               -> classification against seven thresholds -> holdoff.
//               Configuration and thresholds are captured at the trigger edge.
// Ports       : clk_i, rst_i (sync, active high), arm_i, trig_i, adc_dat_i,
//               adc_photon_threshold_1_i..7_i, cfg_delay_i, cfg_window_i,
//               cfg_holdoff_i -> busy_o, pnr_valid_o, pnr_num_o, pnr_peak_o,
//               trig_miss_o.
// Options     : PNR_HIST_EN adds hist_clr_i, hist_sel_i, hist_dat_o and eight
//               32-bit saturating photon-number histogram counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pnr_acq_sequencer #(
  parameter int ADC_W = pnr_pkg::ADC_W,
  parameter int CNT_W = 16,
  parameter int NUM_W = pnr_pkg::NUM_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             trig_i,
  input  logic [ADC_W-1:0] adc_dat_i,
  input  logic [ADC_W-1:0] adc_photon_threshold_1_i,
  input  logic [ADC_W-1:0] adc_photon_threshold_2_i,
  input  logic [ADC_W-1:0] adc_photon_threshold_3_i,
  input  logic [ADC_W-1:0] adc_photon_threshold_4_i,
  input  logic [ADC_W-1:0] adc_photon_threshold_5_i,
  input  logic [ADC_W-1:0] adc_photon_threshold_6_i,
  input  logic [ADC_W-1:0] adc_photon_threshold_7_i,
  input  logic [CNT_W-1:0] cfg_delay_i,
  input  logic [CNT_W-1:0] cfg_window_i,
  input  logic [CNT_W-1:0] cfg_holdoff_i,
`ifdef PNR_HIST_EN
  input  logic             hist_clr_i,
  input  logic [2:0]       hist_sel_i,
  output logic [31:0]      hist_dat_o,
`endif
  output logic             busy_o,
  output logic             pnr_valid_o,
  output logic [NUM_W-1:0] pnr_num_o,
  output logic [ADC_W-1:0] pnr_peak_o,
  output logic [CNT_W-1:0] trig_miss_o
);

  import pnr_pkg::*;

  pnr_state_t               r_state;
  pnr_state_t               w_state_nxt;
  logic                     r_trig_q;
  logic                     w_edge;
  logic                     w_busy;
  logic                     w_start;
  logic [CNT_W-1:0]         r_cnt;       // shared down-counter for all timed states
  logic [CNT_W-1:0]         r_win_eff;   // latched max(window, 1)
  logic [CNT_W-1:0]         r_hold;      // latched holdoff
  logic [CNT_W-1:0]         w_win_eff_in;
  logic                     w_cnt_last;
  logic                     w_first;
  logic [NUM_THR*ADC_W-1:0] r_thr;
  logic [NUM_THR*ADC_W-1:0] w_thr_in;
  logic [ADC_W-1:0]         r_peak;
  logic [NUM_W-1:0]         w_num;

  assign w_edge       = trig_i & ~r_trig_q;
  assign w_busy       = (r_state != ST_IDLE);
  assign w_start      = (r_state == ST_IDLE) & w_edge & arm_i;
  assign busy_o       = w_busy;
  assign w_win_eff_in = (cfg_window_i == '0) ? CNT_W'(1) : cfg_window_i;
  // A count of 0 in HOLDOFF still spends the strobe cycle there.
  assign w_cnt_last   = (r_cnt <= CNT_W'(1));
  // The window counter starts at r_win_eff, so equality marks the first sample.
  assign w_first      = (r_cnt == r_win_eff);
  assign w_thr_in     = {adc_photon_threshold_7_i, adc_photon_threshold_6_i,
                         adc_photon_threshold_5_i, adc_photon_threshold_4_i,
                         adc_photon_threshold_3_i, adc_photon_threshold_2_i,
                         adc_photon_threshold_1_i};

  pnr_classifier #(
    .ADC_W   (ADC_W),
    .NUM_W   (NUM_W),
    .NUM_THR (NUM_THR)
  ) u_classifier (
    .i_peak (r_peak),
    .i_thr  (r_thr),
    .o_num  (w_num)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = (cfg_delay_i == '0) ? ST_WINDOW : ST_DELAY;
        end
      end
      ST_DELAY:    if (w_cnt_last) w_state_nxt = ST_WINDOW;
      ST_WINDOW:   if (w_cnt_last) w_state_nxt = ST_CLASSIFY;
      ST_CLASSIFY: w_state_nxt = ST_HOLDOFF;
      ST_HOLDOFF:  if (w_cnt_last) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath, counters and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_trig_q    <= 1'b0;
      r_cnt       <= '0;
      r_win_eff   <= '0;
      r_hold      <= '0;
      r_thr       <= '0;
      r_peak      <= '0;
      pnr_valid_o <= 1'b0;
      pnr_num_o   <= '0;
      pnr_peak_o  <= '0;
      trig_miss_o <= '0;
    end else begin
      r_trig_q    <= trig_i;
      pnr_valid_o <= 1'b0;

      if (w_edge && w_busy && (trig_miss_o != '1)) begin
        trig_miss_o <= trig_miss_o + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_thr     <= w_thr_in;
            r_win_eff <= w_win_eff_in;
            r_hold    <= cfg_holdoff_i;
            r_cnt     <= (cfg_delay_i == '0) ? w_win_eff_in : cfg_delay_i;
          end
        end
        ST_DELAY: begin
          r_cnt <= w_cnt_last ? r_win_eff : (r_cnt - 1'b1);
        end
        ST_WINDOW: begin
          if (w_first || ($signed(adc_dat_i) > $signed(r_peak))) begin
            r_peak <= adc_dat_i;
          end
          r_cnt <= r_cnt - 1'b1;
        end
        ST_CLASSIFY: begin
          pnr_valid_o <= 1'b1;
          pnr_num_o   <= w_num;
          pnr_peak_o  <= r_peak;
          r_cnt       <= r_hold;
        end
        ST_HOLDOFF: begin
          if (!w_cnt_last) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PNR_HIST_EN
  logic [31:0] r_hist [8];

  // Counts on the strobe cycle; a coincident clear takes priority.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 8; b++) begin
      if (rst_i || hist_clr_i) begin
        r_hist[b] <= '0;
      end else if (pnr_valid_o && (pnr_num_o == NUM_W'(b)) && (r_hist[b] != '1)) begin
        r_hist[b] <= r_hist[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_dat_o <= '0;
    end else begin
      hist_dat_o <= r_hist[hist_sel_i];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pnr_acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pnr_acq_sequencer
// Description : Self-checking bench for pnr_acq_sequencer. Table-driven
//               measurements with a strobe scoreboard, plus hand-written
//               sequences for missed triggers, disarm, reset mid-window and
//               (with PNR_HIST_EN) the histogram.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pnr_acq_sequencer;

  localparam int ADC_W = 14;
  localparam int CNT_W = 16;
  localparam int NUM_W = 3;
  localparam int BG    = 8100;  // out-of-window sample, exposes misaligned windows

  logic             clk = 1'b0;
  logic             rst;
  logic             arm;
  logic             trig;
  logic [ADC_W-1:0] adc;
  logic [ADC_W-1:0] thr [1:7];
  logic [CNT_W-1:0] cfg_d;
  logic [CNT_W-1:0] cfg_w;
  logic [CNT_W-1:0] cfg_h;
  logic             busy_o;
  logic             pnr_valid_o;
  logic [NUM_W-1:0] pnr_num_o;
  logic [ADC_W-1:0] pnr_peak_o;
  logic [CNT_W-1:0] trig_miss_o;
`ifdef PNR_HIST_EN
  logic             hist_clr;
  logic [2:0]       hist_sel;
  logic [31:0]      hist_dat;
`endif

  always #5 clk = ~clk;

  pnr_acq_sequencer #(.ADC_W(ADC_W), .CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .arm_i                    (arm),
    .trig_i                   (trig),
    .adc_dat_i                (adc),
    .adc_photon_threshold_1_i (thr[1]),
    .adc_photon_threshold_2_i (thr[2]),
    .adc_photon_threshold_3_i (thr[3]),
    .adc_photon_threshold_4_i (thr[4]),
    .adc_photon_threshold_5_i (thr[5]),
    .adc_photon_threshold_6_i (thr[6]),
    .adc_photon_threshold_7_i (thr[7]),
    .cfg_delay_i              (cfg_d),
    .cfg_window_i             (cfg_w),
    .cfg_holdoff_i            (cfg_h),
`ifdef PNR_HIST_EN
    .hist_clr_i               (hist_clr),
    .hist_sel_i               (hist_sel),
    .hist_dat_o               (hist_dat),
`endif
    .busy_o                   (busy_o),
    .pnr_valid_o              (pnr_valid_o),
    .pnr_num_o                (pnr_num_o),
    .pnr_peak_o               (pnr_peak_o),
    .trig_miss_o              (trig_miss_o)
  );

  typedef struct {
    int d, w, h;
    int thr_base, thr_step;
    int s0, s1, s2, s3;
    int exp_num, exp_peak;
  } vec_t;

  typedef struct {
    int cyc, num, peak;
  } exp_t;

  vec_t vt [7];
  exp_t sbq [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: actual %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  // Strobe scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (pnr_valid_o) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe @cycle %0d: num %0d peak %0d", cyc,
                 pnr_num_o, $signed(pnr_peak_o));
      end else begin
        e = sbq.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("pnr_num", int'(pnr_num_o), e.num);
        check("pnr_peak", int'($signed(pnr_peak_o)), e.peak);
      end
    end
  end

  task automatic set_vec(input int i, input int d, input int w, input int h,
                         input int tb, input int ts, input int s0, input int s1,
                         input int s2, input int s3, input int n, input int p);
    vt[i].d = d; vt[i].w = w; vt[i].h = h;
    vt[i].thr_base = tb; vt[i].thr_step = ts;
    vt[i].s0 = s0; vt[i].s1 = s1; vt[i].s2 = s2; vt[i].s3 = s3;
    vt[i].exp_num = n; vt[i].exp_peak = p;
  endtask

  function automatic int samp(input int i, input int off);
    case (off)
      0:       return vt[i].s0;
      1:       return vt[i].s1;
      2:       return vt[i].s2;
      default: return vt[i].s3;
    endcase
  endfunction

  task automatic set_cfg(input int d, input int w, input int h, input int tb, input int ts);
    int v;
    cfg_d = CNT_W'(d);
    cfg_w = CNT_W'(w);
    cfg_h = CNT_W'(h);
    for (int k = 1; k <= 7; k++) begin
      v = tb + ts * (k - 1);
      thr[k] = v[ADC_W-1:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a measurement from table entry i and follow it to idle.
  task automatic run_meas(input int i);
    int   t, weff, hold, off, v, t_end;
    exp_t e;
    weff = (vt[i].w == 0) ? 1 : vt[i].w;
    hold = (vt[i].h == 0) ? 1 : vt[i].h;
    trig = 1'b0;
    adc  = ADC_W'(BG);
    step();
    t    = cyc;
    trig = 1'b1;
    arm  = 1'b1;
    set_cfg(vt[i].d, vt[i].w, vt[i].h, vt[i].thr_base, vt[i].thr_step);
    e.cyc  = t + 2 + vt[i].d + weff;
    e.num  = vt[i].exp_num;
    e.peak = vt[i].exp_peak;
    sbq.push_back(e);
    t_end = t + 3 + vt[i].d + weff + hold;
    for (int c = t + 1; c <= t_end; c++) begin
      step();
      if (c == t + 1) begin
        // Disarm and scramble config: the running measurement must ignore both.
        trig = 1'b0;
        arm  = 1'b0;
        set_cfg(7, 9, 5, -8192, 0);
      end
      off = c - (t + 1 + vt[i].d);
      v   = (off >= 0 && off < weff) ? samp(i, off) : BG;
      adc = v[ADC_W-1:0];
      @(negedge clk);
      check($sformatf("busy_v%0d", i), int'(busy_o),
            (c <= t + 1 + vt[i].d + weff + hold) ? 1 : 0);
    end
    check($sformatf("strobe_seen_v%0d", i), sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    int   t, v;
    exp_t e;
    begin : watchdog
      fork
        begin
          #200000;
          $display("FAIL watchdog: simulation time limit reached");
          $fatal(1);
        end
      join_none
    end

    rst = 1'b1; arm = 1'b0; trig = 1'b0; adc = '0;
    set_cfg(0, 0, 0, 0, 0);
`ifdef PNR_HIST_EN
    hist_clr = 1'b0; hist_sel = '0;
`endif

    set_vec(0, 3, 4, 2,   100,  100,    50,  250,  120,    90, 2,   250);
    set_vec(1, 0, 0, 0,  -100, -100, -8000,-8000,-8000, -8000, 0, -8000);
    set_vec(2, 1, 2, 1,   100,  100,   800,   10,   10,    10, 7,   800);
    set_vec(3, 2, 3, 3,   100,  100,   300,  299,   -5,    -5, 3,   300);
    set_vec(4, 5, 4, 0,   700, -100,   -20,  450,  450,   449, 4,   450);
    set_vec(5, 0, 3, 4,  -500,  100, -8192, -350, -351, -8000, 2,  -350);
    set_vec(6, 7, 1, 1,  8191,    0,  8191, 8191, 8191,  8191, 7,  8191);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  int'(busy_o), 0);
    check("rst_valid", int'(pnr_valid_o), 0);
    check("rst_num",   int'(pnr_num_o), 0);
    check("rst_peak",  int'(pnr_peak_o), 0);
    check("rst_miss",  int'(trig_miss_o), 0);

    for (int i = 0; i < 7; i++) run_meas(i);
    check("miss_after_table", int'(trig_miss_o), exp_miss);

`ifdef PNR_HIST_EN
    step(); hist_clr = 1'b1;
    step(); hist_clr = 1'b0;
    for (int r = 0; r < 5; r++) run_meas(0);
    run_meas(2);
    hist_sel = 3'd2; step(); @(negedge clk);
    check("hist2", int'(hist_dat), 5);
    hist_sel = 3'd7; step(); @(negedge clk);
    check("hist7", int'(hist_dat), 1);
    hist_clr = 1'b1; step(); hist_clr = 1'b0;
    hist_sel = 3'd2; step(); @(negedge clk);
    check("hist2_clr", int'(hist_dat), 0);
    hist_sel = 3'd7; step(); @(negedge clk);
    check("hist7_clr", int'(hist_dat), 0);
`endif

    // Extra edges while busy, the last one on the final holdoff cycle.
    trig = 1'b0; adc = ADC_W'(BG); step();
    t = cyc; trig = 1'b1; arm = 1'b1;
    set_cfg(2, 20, 1, 100, 100);
    e.cyc = t + 24; e.num = 1; e.peak = 150;
    sbq.push_back(e);
    for (int c = t + 1; c <= t + 27; c++) begin
      step();
      trig = (c == t + 3 || c == t + 8 || c == t + 15 || c == t + 24);
      v    = (c >= t + 3 && c <= t + 22) ? 150 : BG;
      adc  = v[ADC_W-1:0];
      @(negedge clk);
      check("miss_busy", int'(busy_o), (c <= t + 24) ? 1 : 0);
    end
    exp_miss = 4;
    check("miss_strobe_seen", sbq.size(), 0);
    sbq.delete();
    check("miss_count", int'(trig_miss_o), exp_miss);

    // Disarmed edges in IDLE: nothing starts, nothing counted.
    arm = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      trig = (c % 3 == 1);
      @(negedge clk);
      check("disarm_busy", int'(busy_o), 0);
    end
    trig = 1'b0;
    check("disarm_miss", int'(trig_miss_o), exp_miss);

    // Reset in the middle of the window.
    step();
    t = cyc; trig = 1'b1; arm = 1'b1;
    set_cfg(1, 10, 2, 100, 100);
    for (int c = t + 1; c <= t + 4; c++) begin
      step();
      trig = 1'b0;
      adc  = ADC_W'(100);
      if (c == t + 4) rst = 1'b1;
    end
    step();
    rst = 1'b0;
    exp_miss = 0;
    @(negedge clk);
    check("rstmid_busy",  int'(busy_o), 0);
    check("rstmid_valid", int'(pnr_valid_o), 0);
    check("rstmid_num",   int'(pnr_num_o), 0);
    check("rstmid_peak",  int'(pnr_peak_o), 0);
    check("rstmid_miss",  int'(trig_miss_o), exp_miss);
    for (int c = 0; c < 15; c++) begin
      step();
      @(negedge clk);
      check("rstmid_idle", int'(busy_o), 0);
    end

    run_meas(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
